config_loader: RTL and testbench
================================

# config_loader

Byte-wide configuration loader that sits directly upstream of the CLB configuration scan chain. It accepts a bitstream from the host over a valid/ready byte interface and serialises it onto the chain's `cfg_in`/`cfg_en` pins, one bit per `cfg_clk` cycle. It verifies an XOR checksum byte that trails the payload, and reports completion and errors. It drives a single chain of `NUM_CLBS` daisy-chained CLBs, each holding `CONFIG_SIZE` bits.

## Interface
- `CONFIG_SIZE`, 37: configuration bits per CLB.
- `NUM_CLBS`, 1: number of CLBs in the chain. `CHAIN_LEN = CONFIG_SIZE*NUM_CLBS` must be ≥ 1.
- `cfg_clk`  in  1  sole clock. The CLB chain shifts on the same edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a load. Sampled only in IDLE.
- `abort`  in  1  terminates any load in progress and returns to IDLE.
- `in_data`  in  8  host byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `cfg_out`  out  1  serial bit; connects to the chain's `cfg_in`.
- `cfg_en`  out  1  shift enable; connects to the chain's `cfg_en`.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a load completes.
- `err`  out  1  sticky checksum-mismatch flag.

## Operation
- `NBYTES = ceil(CHAIN_LEN/8)`. Payload is `NBYTES` bytes followed by one checksum byte.
- Checksum = XOR of all `NBYTES` payload bytes, including unused high bits of the last byte.
- Bit order:
  - Each byte is emitted LSB first.
  - Stream bit k is byte k/8, bit k%8.
  - Stream bit 0 is emitted first and therefore ends deepest in the chain.
- States:
  - IDLE: `start` → FETCH. Clears `err`, the bit counter, and the running checksum.
  - FETCH: `in_ready`=1. On `in_valid & in_ready`:
    - latch byte into the shift register;
    - XOR it into the running checksum;
    - go to SHIFT.
  - SHIFT: `cfg_en`=1 and `cfg_out`=shift_reg[0] every cycle; shift right and increment the bit counter. Exit rules:
    - After 8 bits → FETCH.
    - Once the counter reaches `CHAIN_LEN` → CHECK, even mid-byte; remaining bits are discarded.
  - CHECK: `in_ready`=1. On handshake:
    - compare the byte with the running checksum;
    - set `err` if they differ;
    - go to IDLE with `done`=1 the following cycle.
- `cfg_out` = 0 whenever `cfg_en` = 0.
- `abort` (any non-IDLE state) → IDLE next cycle:
  - no `done` pulse, and `err` is unchanged;
  - chain contents are undefined; the host must restart the load.
- `abort` and `start` asserted together in IDLE: `abort` wins and the loader stays in IDLE.
- `start` while busy: ignored.
- Bit counter width: `$clog2(CHAIN_LEN+1)`. No wrap is possible because SHIFT exits at `CHAIN_LEN`.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`, `cfg_en`, `cfg_out`, `busy`, `done`, `err` all 0;
  - counters and checksum 0.
- Reset takes effect on the next `cfg_clk` edge, including mid-load. The chain keeps any bits already shifted.
- `start` asserted at edge t0 → `busy`=1 and `in_ready`=1 from t0+1.
- Handshake at edge t → first `cfg_en`=1 cycle is t+1.
- Each full byte costs 1 FETCH cycle + 8 SHIFT cycles with zero stall. The final byte costs 1 + (`CHAIN_LEN` − 8·(`NBYTES`−1)) cycles.
- Host stalls (`in_valid`=0) hold FETCH/CHECK indefinitely with `cfg_en`=0. The chain is not shifted while stalled.
- `in_ready` is never high in SHIFT or IDLE. A byte offered then is not consumed.
- Zero-stall load with `CHAIN_LEN`=37 from `start` at t0:
  - SHIFT cycles total 37;
  - CHECK handshake at t0+43;
  - `done`=1 at t0+44 only;
  - `busy` is high t0+1 through t0+43.
- `err` updates in the same cycle `done` pulses and holds until the next accepted `start`.

## Test plan
- Nominal, 37 bits:
  - Stimulus: bytes 0xA5, 0x3C, 0xFF, 0x00, 0x1B; checksum 0x7D; `in_valid` always 1.
  - Required: exactly 37 `cfg_en` cycles; `cfg_out` sequence equal to the LSB-first bits of the stream (last byte contributes bits 0–4 only); `done` at t0+44; `err`=0.
- Bad checksum:
  - Stimulus: same payload, checksum 0x7C.
  - Required: `done` pulses and `err`=1; a following `start` clears `err` to 0 at t0+1.
- Host stalls:
  - Stimulus: `in_valid` low for 3 cycles before each byte.
  - Required: `cfg_en` stays 0 during stalls; same 37-bit `cfg_out` sequence as the nominal case; `done` at t0+59.
- Abort mid-shift:
  - Stimulus: `abort` asserted on the 4th SHIFT cycle of byte 2.
  - Required: `cfg_en`=0 and IDLE on the next cycle; no `done`; `err` unchanged; a new load then completes normally.
- Reset mid-load:
  - Stimulus: `reset` asserted during CHECK.
  - Required: all outputs 0 next cycle; the checksum byte offered in that cycle is not consumed.
- `NUM_CLBS`=2:
  - `CHAIN_LEN`=74, so `NBYTES`=10.
  - Required: 74 `cfg_en` cycles, the last byte contributing 2 bits; correct checksum → `done` with `err`=0.

Source files
------------

// File: rtl/config_loader.sv
// config_loader: accepts a host bitstream byte by byte, shifts it LSB-first into the CLB scan chain and checks a trailing XOR checksum.
// Latency: a byte handshake at edge t drives the first cfg_en cycle at t+1; 1 fetch + 8 shift cycles per full byte; done one cycle after the checksum handshake.
// Backpressure: in_ready only in FETCH/CHECK (masked by abort/reset); host stalls hold the loader with cfg_en=0 so the chain never shifts while waiting.
module config_loader #(
  parameter int CONFIG_SIZE = 37,
  parameter int NUM_CLBS    = 1
) (
  input  logic       i_cfg_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [7:0] i_in_data,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic       o_cfg_out,
  output logic       o_cfg_en,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int CHAIN_LEN = CONFIG_SIZE * NUM_CLBS;
  localparam int CW        = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_sr;
  logic [7:0]      r_csum;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic            r_done;
  logic            r_err;

  logic            w_in_ready;
  logic            w_hs;
  logic            w_last_chain;
  logic            w_last_in_byte;

  // Handshake qualifiers: abort or reset in the same cycle means the offered byte is not taken.
  always_comb begin
    w_in_ready     = ((r_state == S_FETCH) || (r_state == S_CHECK)) && !i_abort && !i_reset;
    w_hs           = w_in_ready && i_in_valid;
    w_last_chain   = (r_cnt == LAST_BIT);
    w_last_in_byte = (r_bit == 3'd7);
  end

  // State register.
  always_ff @(posedge i_cfg_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; the chain-length exit takes priority over the byte boundary.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (i_abort)   w_next = S_IDLE;
        else if (w_hs) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (i_abort)             w_next = S_IDLE;
        else if (w_last_chain)   w_next = S_CHECK;
        else if (w_last_in_byte) w_next = S_FETCH;
      end
      S_CHECK: begin
        if (i_abort)   w_next = S_IDLE;
        else if (w_hs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: cfg_out is forced low whenever the chain is not being shifted.
  always_comb begin
    o_in_ready = w_in_ready;
    o_cfg_en   = (r_state == S_SHIFT);
    o_cfg_out  = (r_state == S_SHIFT) && r_sr[0];
    o_busy     = (r_state != S_IDLE);
    o_done     = r_done;
    o_err      = r_err;
  end

  // Datapath: shift register, running checksum, counters, done pulse and sticky error.
  always_ff @(posedge i_cfg_clk) begin
    if (i_reset) begin
      r_sr   <= 8'h00;
      r_csum <= 8'h00;
      r_cnt  <= '0;
      r_bit  <= 3'd0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            r_sr   <= 8'h00;
            r_csum <= 8'h00;
            r_cnt  <= '0;
            r_bit  <= 3'd0;
            r_err  <= 1'b0;
          end
        end
        S_FETCH: begin
          if (w_hs) begin
            r_sr   <= i_in_data;
            r_csum <= r_csum ^ i_in_data;
            r_bit  <= 3'd0;
          end
        end
        S_SHIFT: begin
          r_sr  <= {1'b0, r_sr[7:1]};
          r_cnt <= r_cnt + CNT_ONE;
          r_bit <= r_bit + 3'd1;
        end
        S_CHECK: begin
          if (w_hs) begin
            r_err  <= (i_in_data != r_csum);
            r_done <= 1'b1;
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: drives both a 37-bit and a 74-bit chain loader against a count-based transaction model.
// Directed loads pin exact cycle timing and the serial bit stream; a random phase exercises stalls, aborts, resets and checksum errors.
// One compare process checks every output of the selected instance on every falling edge.
module tb_config_loader;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       sel = 1'b0;

  logic start_a, valid_a, start_b, valid_b;
  logic rdy_a, out_a, en_a, busy_a, done_a, err_a;
  logic rdy_b, out_b, en_b, busy_b, done_b, err_b;
  logic rdy, cout, en, busy, done, err;

  assign start_a = start & ~sel;
  assign valid_a = in_valid & ~sel;
  assign start_b = start & sel;
  assign valid_b = in_valid & sel;

  assign rdy  = sel ? rdy_b  : rdy_a;
  assign cout = sel ? out_b  : out_a;
  assign en   = sel ? en_b   : en_a;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
  assign err  = sel ? err_b  : err_a;

  config_loader #(.CONFIG_SIZE(37), .NUM_CLBS(1)) dut_a (
    .i_cfg_clk(clk), .i_reset(reset), .i_start(start_a), .i_abort(abort),
    .i_in_data(in_data), .i_in_valid(valid_a), .o_in_ready(rdy_a),
    .o_cfg_out(out_a), .o_cfg_en(en_a), .o_busy(busy_a), .o_done(done_a), .o_err(err_a)
  );

  config_loader #(.CONFIG_SIZE(37), .NUM_CLBS(2)) dut_b (
    .i_cfg_clk(clk), .i_reset(reset), .i_start(start_b), .i_abort(abort),
    .i_in_data(in_data), .i_in_valid(valid_b), .o_in_ready(rdy_b),
    .o_cfg_out(out_b), .o_cfg_en(en_b), .o_busy(busy_b), .o_done(done_b), .o_err(err_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: bits emitted, bytes accepted, bits left in the current byte.
  bit         m_busy = 1'b0;
  int         m_left = 0;
  int         m_bits = 0;
  int         m_nb = 0;
  logic [7:0] m_csum = 8'h00;
  bit         m_err = 1'b0;
  bit         m_done = 1'b0;
  logic [7:0] m_bytes [16] = '{default: 8'h00};

  // Observation for directed checks.
  bit         cap [$];
  int         en_cnt = 0;
  int         busy_cnt = 0;
  int         done_cyc = -1;
  logic [7:0] tb_bytes [16] = '{default: 8'h00};

  function automatic int clen();
    return sel ? 74 : 37;
  endfunction

  function automatic int nbytes();
    return sel ? 10 : 5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic e_rdy, e_en, e_out;
    logic [7:0] cur;
    e_rdy = m_busy && (m_left == 0) && !reset && !abort;
    e_en  = m_busy && (m_left > 0);
    cur   = m_bytes[m_bits / 8];
    e_out = e_en ? cur[m_bits % 8] : 1'b0;
    chk("busy",     32'(busy), 32'(m_busy));
    chk("in_ready", 32'(rdy),  32'(e_rdy));
    chk("cfg_en",   32'(en),   32'(e_en));
    chk("cfg_out",  32'(cout), 32'(e_out));
    chk("done",     32'(done), 32'(m_done));
    chk("err",      32'(err),  32'(m_err));
    if (en === 1'b1) begin
      cap.push_back(cout);
      en_cnt++;
    end
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cyc = cyc + 1;
    // Advance the model with the inputs that the next rising edge will sample.
    if (reset) begin
      m_busy = 0; m_left = 0; m_bits = 0; m_nb = 0; m_csum = 8'h00; m_err = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start && !abort) begin
          m_busy = 1; m_left = 0; m_bits = 0; m_nb = 0; m_csum = 8'h00; m_err = 0;
        end
      end else if (abort) begin
        m_busy = 0;
        m_left = 0;
      end else if (m_left > 0) begin
        m_bits++;
        m_left--;
        if (m_bits == clen()) m_left = 0;
      end else if (in_valid) begin
        if (m_nb < nbytes()) begin
          m_bytes[m_nb] = in_data;
          m_csum = m_csum ^ in_data;
          m_nb++;
          m_left = (clen() - m_bits < 8) ? clen() - m_bits : 8;
        end else begin
          m_err  = (in_data != m_csum);
          m_done = 1;
          m_busy = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic new_sel);
    reset = 1; start = 0; abort = 0; in_valid = 0;
    step();
    sel = new_sel;
    step();
    reset = 0;
  endtask

  task automatic wait_rdy(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout actual=0 required=1 t=%0t", $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    bit ok;
    if (stall > 0) begin
      in_valid = 0;
      wait_rdy(ok);
      repeat (stall) step();
    end
    in_valid = 1;
    in_data  = b;
    wait_rdy(ok);
    step();
    in_valid = 0;
  endtask

  task automatic run_load(input int nb, input logic [7:0] csum, input int stall,
                          input int abort_byte, output int t0);
    cap.delete();
    en_cnt = 0; busy_cnt = 0; done_cyc = -1;
    start = 1;
    t0 = cyc + 1;
    step();
    start = 0;
    for (int i = 0; i < nb; i++) begin
      send_byte(tb_bytes[i], stall);
      if (i == abort_byte) begin
        repeat (3) step();
        abort = 1;
        step();
        abort = 0;
        return;
      end
    end
    send_byte(csum, 0);
    repeat (2) step();
  endtask

  task automatic chk_stream(input string name, input int len);
    int mism;
    logic [7:0] b;
    mism = 0;
    for (int k = 0; k < len && k < cap.size(); k++) begin
      b = tb_bytes[k / 8];
      if (cap[k] !== b[k % 8]) mism++;
    end
    chk({name, "_len"}, 32'(cap.size()), 32'(len));
    chk({name, "_bits"}, 32'(mism), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    logic [7:0] cs;

    do_reset(1'b0);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdy",  32'(rdy),  0);
    chk("rst_en",   32'(en),   0);
    chk("rst_out",  32'(cout), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err",  32'(err),  0);
    step();

    // Nominal 37-bit load.
    tb_bytes[0] = 8'hA5; tb_bytes[1] = 8'h3C; tb_bytes[2] = 8'hFF;
    tb_bytes[3] = 8'h00; tb_bytes[4] = 8'h1B;
    run_load(5, 8'h7D, 0, -1, t0);
    chk("nom_en_cnt", 32'(en_cnt), 37);
    chk_stream("nom_stream", 37);
    chk("nom_done_cyc", 32'(done_cyc), 32'(t0 + 44));
    chk("nom_busy_cnt", 32'(busy_cnt), 43);
    chk("nom_err", 32'(err), 0);

    // Bad checksum, then a new start clears err one cycle later.
    run_load(5, 8'h7C, 0, -1, t0);
    chk("bad_done_cyc", 32'(done_cyc), 32'(t0 + 44));
    chk("bad_err", 32'(err), 1);
    start = 1;
    step();
    start = 0;
    @(negedge clk);
    chk("restart_err", 32'(err), 0);
    chk("restart_busy", 32'(busy), 1);
    step();
    abort = 1;
    step();
    abort = 0;

    // Host stalls of 3 cycles before each payload byte.
    run_load(5, 8'h7D, 3, -1, t0);
    chk("stall_en_cnt", 32'(en_cnt), 37);
    chk_stream("stall_stream", 37);
    chk("stall_done_cyc", 32'(done_cyc), 32'(t0 + 59));
    chk("stall_err", 32'(err), 0);

    // Abort on the 4th shift cycle of the second byte.
    run_load(5, 8'h7D, 0, 1, t0);
    @(negedge clk);
    chk("abort_en", 32'(en), 0);
    chk("abort_busy", 32'(busy), 0);
    step();
    repeat (3) step();
    chk("abort_no_done", 32'(done_cyc), 32'hFFFFFFFF);
    chk("abort_err", 32'(err), 0);
    run_load(5, 8'h7D, 0, -1, t0);
    chk("after_abort_done_cyc", 32'(done_cyc), 32'(t0 + 44));
    chk("after_abort_err", 32'(err), 0);

    // Reset while in CHECK with the checksum byte on offer.
    cap.delete(); en_cnt = 0; done_cyc = -1;
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 5; i++) send_byte(tb_bytes[i], 0);
    begin
      bit ok;
      wait_rdy(ok);
    end
    step();
    reset = 1; in_valid = 1; in_data = 8'h7D;
    step();
    reset = 0; in_valid = 0;
    @(negedge clk);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_rdy",  32'(rdy),  0);
    chk("mrst_en",   32'(en),   0);
    chk("mrst_out",  32'(cout), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_err",  32'(err),  0);
    step();
    repeat (3) step();
    chk("mrst_no_done", 32'(done_cyc), 32'hFFFFFFFF);

    // Two-CLB chain: 74 bits, 10 bytes, last byte contributes 2 bits.
    do_reset(1'b1);
    cs = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tb_bytes[i] = 8'($urandom);
      cs = cs ^ tb_bytes[i];
    end
    run_load(10, cs, 0, -1, t0);
    chk("c2_en_cnt", 32'(en_cnt), 74);
    chk_stream("c2_stream", 74);
    chk("c2_done_cyc", 32'(done_cyc), 32'(t0 + 86));
    chk("c2_err", 32'(err), 0);

    // Random traffic on both instances against the model.
    for (int s = 0; s < 2; s++) begin
      do_reset(s == 1);
      for (int c = 0; c < 1500; c++) begin
        start    = ($urandom_range(0, 9) == 0);
        abort    = ($urandom_range(0, 199) == 0);
        reset    = ($urandom_range(0, 799) == 0);
        in_valid = ($urandom_range(0, 9) < 7);
        if (m_busy && m_left == 0 && m_nb == nbytes() && $urandom_range(0, 1) == 1)
          in_data = m_csum;
        else
          in_data = 8'($urandom);
        step();
      end
    end
    start = 0; abort = 0; reset = 0; in_valid = 0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
